// File: rtl/uproc_pkg.sv
// uproc_pkg: state and grant encodings shared by the uProcesador data-memory arbiter.
package uproc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arbState_t;
  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_LDR = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin choice between CPU and loader; remembers the last winner.
module rr_arbiter2 import uproc_pkg::*; (
  input  logic clk,
  input  logic rstN,
  input  logic reqCpu,
  input  logic reqLdr,
  input  logic take,
  output logic anyReq,
  output logic gntId
);
  logic lastGrant;
  assign anyReq = reqCpu | reqLdr;
  assign gntId = (reqCpu & reqLdr) ? ~lastGrant : (reqLdr ? GNT_LDR : GNT_CPU);
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) lastGrant <= GNT_LDR;
    else if (take) lastGrant <= gntId;
endmodule

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: shares the Data_Memory port between the CPU datapath and the loader,
// inserting WAIT_STATES cycles per access and returning a one-cycle ack to the winner.
module data_memory_arbiter import uproc_pkg::*; #(
  parameter int DATAWIDTH_BUS = 32,
  parameter int WAIT_STATES   = 2,
  parameter int WAITCNT_WIDTH = 3
) (
  input  logic                     DataMemArb_CLOCK_50,
  input  logic                     DataMemArb_RESET_InLow,
  input  logic                     DataMemArb_CPU_Req,
  input  logic                     DataMemArb_CPU_WR,
  input  logic [DATAWIDTH_BUS-1:0] DataMemArb_CPU_Addr,
  input  logic [DATAWIDTH_BUS-1:0] DataMemArb_CPU_WData,
  output logic                     DataMemArb_CPU_Ack,
  output logic                     DataMemArb_CPU_Stall,
  input  logic                     DataMemArb_LDR_Req,
  input  logic                     DataMemArb_LDR_WR,
  input  logic [DATAWIDTH_BUS-1:0] DataMemArb_LDR_Addr,
  input  logic [DATAWIDTH_BUS-1:0] DataMemArb_LDR_WData,
  output logic                     DataMemArb_LDR_Ack,
  output logic [DATAWIDTH_BUS-1:0] DataMemArb_RData,
  output logic                     DataMemArb_Mem_RD,
  output logic                     DataMemArb_Mem_WR,
  output logic [DATAWIDTH_BUS-1:0] DataMemArb_Mem_Addr,
  output logic [DATAWIDTH_BUS-1:0] DataMemArb_Mem_WData,
  input  logic [DATAWIDTH_BUS-1:0] DataMemArb_Mem_RData
);
  arbState_t state, stateNext;
  logic [WAITCNT_WIDTH-1:0] waitCnt;
  logic [DATAWIDTH_BUS-1:0] addrReg, wdataReg, rdataReg;
  logic wrReg, gntReg, anyReq, gntId, grantNow, lastWait, inAccess, inResp;

  rr_arbiter2 uArb (
    .clk   (DataMemArb_CLOCK_50),
    .rstN  (DataMemArb_RESET_InLow),
    .reqCpu(DataMemArb_CPU_Req),
    .reqLdr(DataMemArb_LDR_Req),
    .take  (grantNow),
    .anyReq(anyReq),
    .gntId (gntId)
  );

  assign grantNow = (state == IDLE) & anyReq;
  assign lastWait = waitCnt == WAITCNT_WIDTH'(WAIT_STATES);
  assign inAccess = state == ACCESS;
  assign inResp = state == RESP;

  always_comb begin
    stateNext = IDLE;
    if (grantNow) stateNext = ACCESS;
    else if (inAccess) stateNext = lastWait ? RESP : ACCESS;
  end

  // Address, data and direction are captured at grant so requesters may move on mid-access.
  always_ff @(posedge DataMemArb_CLOCK_50 or negedge DataMemArb_RESET_InLow)
    if (!DataMemArb_RESET_InLow) begin
      state <= IDLE;
      waitCnt <= '0;
      wrReg <= 1'b0;
      gntReg <= GNT_CPU;
      addrReg <= '0;
      wdataReg <= '0;
      rdataReg <= '0;
    end else begin
      state <= stateNext;
      waitCnt <= (inAccess && !lastWait) ? waitCnt + 1'b1 : '0;
      if (grantNow) begin
        gntReg <= gntId;
        wrReg <= gntId ? DataMemArb_LDR_WR : DataMemArb_CPU_WR;
        addrReg <= gntId ? DataMemArb_LDR_Addr : DataMemArb_CPU_Addr;
        wdataReg <= gntId ? DataMemArb_LDR_WData : DataMemArb_CPU_WData;
      end
      if (inAccess && lastWait && !wrReg) rdataReg <= DataMemArb_Mem_RData;
    end

  assign DataMemArb_Mem_RD = inAccess & ~wrReg;
  assign DataMemArb_Mem_WR = inAccess & wrReg;
  assign DataMemArb_CPU_Ack = inResp & (gntReg == GNT_CPU);
  assign DataMemArb_LDR_Ack = inResp & (gntReg == GNT_LDR);
  assign DataMemArb_CPU_Stall = DataMemArb_CPU_Req & ~DataMemArb_CPU_Ack;
  assign DataMemArb_Mem_Addr = addrReg;
  assign DataMemArb_Mem_WData = wdataReg;
  assign DataMemArb_RData = rdataReg;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed table, hand sequences and random transactions against a
// transaction-level model of the arbiter (round-robin order, fixed access period, captured requests).
module tb_data_memory_arbiter;
  localparam int W = 32;
  localparam int WS = 2;
  logic clk = 1'b0;
  logic rstN, cpuReq, cpuWr, ldrReq, ldrWr, cpuReq0;
  logic [W-1:0] cpuAddr, cpuWData, ldrAddr, ldrWData;
  logic cpuAck, cpuStall, ldrAck, memRd, memWr;
  logic [W-1:0] rData, memAddr, memWData, memRData;
  logic cpuAck0, cpuStall0, ldrAck0, memRd0, memWr0;
  logic [W-1:0] rData0, memAddr0, memWData0, memRData0;
  int vectors = 0, miscompares = 0;
  logic modelLast;
  logic [W-1:0] rdModel;

  typedef struct {
    logic doCpu, doLdr, cWr, lWr;
    logic [W-1:0] cA, cD, lA, lD;
    logic chg, firstLdr;
    logic [W-1:0] rdAfter;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  function automatic logic [W-1:0] memFn(input logic [W-1:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction
  // Read data is only meaningful while the read strobe is up.
  assign memRData = memRd ? memFn(memAddr) : 32'hBAD0BAD0;
  assign memRData0 = memRd0 ? memFn(memAddr0) : 32'hBAD0BAD0;

  data_memory_arbiter #(.DATAWIDTH_BUS(W), .WAIT_STATES(WS), .WAITCNT_WIDTH(3)) dut (
    .DataMemArb_CLOCK_50(clk), .DataMemArb_RESET_InLow(rstN),
    .DataMemArb_CPU_Req(cpuReq), .DataMemArb_CPU_WR(cpuWr),
    .DataMemArb_CPU_Addr(cpuAddr), .DataMemArb_CPU_WData(cpuWData),
    .DataMemArb_CPU_Ack(cpuAck), .DataMemArb_CPU_Stall(cpuStall),
    .DataMemArb_LDR_Req(ldrReq), .DataMemArb_LDR_WR(ldrWr),
    .DataMemArb_LDR_Addr(ldrAddr), .DataMemArb_LDR_WData(ldrWData),
    .DataMemArb_LDR_Ack(ldrAck), .DataMemArb_RData(rData),
    .DataMemArb_Mem_RD(memRd), .DataMemArb_Mem_WR(memWr),
    .DataMemArb_Mem_Addr(memAddr), .DataMemArb_Mem_WData(memWData),
    .DataMemArb_Mem_RData(memRData)
  );

  data_memory_arbiter #(.DATAWIDTH_BUS(W), .WAIT_STATES(0), .WAITCNT_WIDTH(3)) dut0 (
    .DataMemArb_CLOCK_50(clk), .DataMemArb_RESET_InLow(rstN),
    .DataMemArb_CPU_Req(cpuReq0), .DataMemArb_CPU_WR(cpuWr),
    .DataMemArb_CPU_Addr(cpuAddr), .DataMemArb_CPU_WData(cpuWData),
    .DataMemArb_CPU_Ack(cpuAck0), .DataMemArb_CPU_Stall(cpuStall0),
    .DataMemArb_LDR_Req(1'b0), .DataMemArb_LDR_WR(1'b0),
    .DataMemArb_LDR_Addr('0), .DataMemArb_LDR_WData('0),
    .DataMemArb_LDR_Ack(ldrAck0), .DataMemArb_RData(rData0),
    .DataMemArb_Mem_RD(memRd0), .DataMemArb_Mem_WR(memWr0),
    .DataMemArb_Mem_Addr(memAddr0), .DataMemArb_Mem_WData(memWData0),
    .DataMemArb_Mem_RData(memRData0)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // One or two competing requests; each access occupies WS+3 cycles (access, ack, idle).
  task automatic runTx(input logic doCpu, input logic doLdr, input logic cWr, input logic lWr,
                       input logic [W-1:0] cA, input logic [W-1:0] cD, input logic [W-1:0] lA,
                       input logic [W-1:0] lD, input logic chg, input logic firstLdr);
    logic [W-1:0] addrs[2], datas[2];
    logic wrs[2], ids[2];
    logic acc, ack, ackC, ackL;
    int n, slot, pos;
    n = (doCpu && doLdr) ? 2 : 1;
    ids[0] = firstLdr;
    ids[1] = ~firstLdr;
    for (int i = 0; i < 2; i++) begin
      addrs[i] = ids[i] ? lA : cA;
      datas[i] = ids[i] ? lD : cD;
      wrs[i] = ids[i] ? lWr : cWr;
    end
    cpuReq = doCpu; cpuWr = cWr; cpuAddr = cA; cpuWData = cD;
    ldrReq = doLdr; ldrWr = lWr; ldrAddr = lA; ldrWData = lD;
    for (int c = 1; c <= n * (WS + 3); c++) begin
      @(negedge clk);
      slot = (c - 1) / (WS + 3);
      pos = (c - 1) % (WS + 3);
      acc = pos <= WS;
      ack = pos == WS + 1;
      ackC = ack & ~ids[slot];
      ackL = ack & ids[slot];
      check("strobes/acks/stall", {27'd0, memRd, memWr, cpuAck, ldrAck, cpuStall},
            {27'd0, acc & ~wrs[slot], acc & wrs[slot], ackC, ackL, cpuReq & ~ackC});
      if (acc) check("mem addr", memAddr, addrs[slot]);
      if (acc && wrs[slot]) check("mem wdata", memWData, datas[slot]);
      if (ack) begin
        if (!wrs[slot]) rdModel = memFn(addrs[slot]);
        check("rdata at ack", rData, rdModel);
        if (ids[slot]) ldrReq = 1'b0;
        else cpuReq = 1'b0;
      end
      if (chg && c == 1) begin
        if (ids[0]) begin ldrAddr = lA + 32'h10; ldrWData = ~lD; ldrWr = ~lWr; end
        else begin cpuAddr = cA + 32'h10; cpuWData = ~cD; cpuWr = ~cWr; end
      end
    end
    modelLast = ids[n-1];
  endtask

  initial begin
    logic [1:0] sel;
    logic dc, dl;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'h04, 32'h12345678, 1'b0, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h20, 32'hAAAA5555, 32'h30, 32'h0, 1'b0, 1'b0, 32'h5A6AFFFF};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h5A7AFFFF};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 32'h10, 32'h0, 1'b0, 1'b1, 32'h5A1AFFFF};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h10000008, 32'h0, 1'b0, 1'b1, 32'h5A52EFFF};
    rstN = 1'b0;
    {cpuReq, cpuWr, ldrReq, ldrWr, cpuReq0} = '0;
    {cpuAddr, cpuWData, ldrAddr, ldrWData} = '0;
    modelLast = 1'b1;
    rdModel = '0;
    repeat (2) @(negedge clk);
    check("reset ctrl", {27'd0, cpuAck, cpuStall, ldrAck, memRd, memWr}, '0);
    check("reset mem addr", memAddr, '0);
    check("reset mem wdata", memWData, '0);
    check("reset rdata", rData, '0);
    rstN = 1'b1;

    for (int i = 0; i < 6; i++) begin
      runTx(tbl[i].doCpu, tbl[i].doLdr, tbl[i].cWr, tbl[i].lWr, tbl[i].cA, tbl[i].cD,
            tbl[i].lA, tbl[i].lD, tbl[i].chg, tbl[i].firstLdr);
      check("table rdata", rData, tbl[i].rdAfter);
    end

    cpuAddr = 32'h10; cpuWr = 1'b0; cpuWData = 32'h77; cpuReq0 = 1'b1;
    @(negedge clk);
    check("ws0 access", {27'd0, memRd0, memWr0, cpuAck0, ldrAck0, cpuStall0}, 32'b10001);
    @(negedge clk);
    check("ws0 ack", {27'd0, memRd0, memWr0, cpuAck0, ldrAck0, cpuStall0}, 32'b00100);
    check("ws0 rdata", rData0, 32'hDEADBEEF);
    check("ws0 wdata capture", memWData0, 32'h77);
    cpuReq0 = 1'b0;
    @(negedge clk);
    check("ws0 idle", {27'd0, memRd0, memWr0, cpuAck0, ldrAck0, cpuStall0}, '0);

    cpuAddr = 32'h44; cpuWr = 1'b0; cpuReq = 1'b1;
    repeat (2) @(negedge clk);
    check("pre-reset read strobe", {31'd0, memRd}, 32'd1);
    #2 rstN = 1'b0;
    #1 check("async reset drop", {28'd0, memRd, memWr, cpuAck, ldrAck}, '0);
    cpuReq = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    modelLast = 1'b1;
    rdModel = '0;
    check("rdata after reset", rData, '0);
    runTx(1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 32'h08, 32'hCAFEF00D, 1'b0, 1'b0);
    check("post-reset rdata", rData, 32'hDEADBEEF);

    for (int k = 0; k < 40; k++) begin
      sel = 2'($urandom_range(1, 3));
      dc = sel[0];
      dl = sel[1];
      runTx(dc, dl, 1'($urandom), 1'($urandom), {16'h0, 14'($urandom), 2'b00}, $urandom,
            {16'h0, 14'($urandom), 2'b00}, $urandom, $urandom_range(0, 3) == 0,
            (dc && dl) ? ~modelLast : dl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
